// File: rtl/final_norm_round_pipe.sv
// Three-stage final normalise/round for the MAC datapath: magnitude, leading-one
// normalise with guard/round/sticky, then round, exponent adjust and range check.
module final_norm_round_pipe #(
  parameter int SUM_W = 19,
  parameter int MAN_W = 11,
  parameter int POINT = 13,
  parameter int EXP_W = 5,
  parameter int SH_W  = $clog2(SUM_W) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [SUM_W-1:0] i_sum,
  input  logic [EXP_W-1:0] i_exp,
  input  logic             i_rnd_mode,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_sign,
  output logic [MAN_W-1:0] o_man,
  output logic [EXP_W-1:0] o_exp,
  output logic [SH_W-1:0]  o_shift,
  output logic             o_zero,
  output logic             o_ovf,
  output logic             o_unf
);

  localparam int STAGES = 3;
  localparam int LW     = $clog2(SUM_W);
  localparam int EW     = EXP_W + 2;
  localparam logic [LW-1:0] TOP  = LW'(SUM_W - 1);
  localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  typedef struct packed {
    logic             sign;
    logic             rtz;
    logic [EXP_W-1:0] exp;
    logic [SUM_W-1:0] mag;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic             rtz;
    logic             zero;
    logic [EXP_W-1:0] exp;
    logic [SH_W-1:0]  shift;
    logic [MAN_W-1:0] man;
    logic             rbit;
    logic             sticky;
  } s2_t;

  typedef struct packed {
    logic             sign;
    logic [MAN_W-1:0] man;
    logic [EXP_W-1:0] exp;
    logic [SH_W-1:0]  shift;
    logic             zero;
    logic             ovf;
    logic             unf;
  } s3_t;

  logic [STAGES:1] vld_q, vld_d;
  logic [STAGES:0] vld_pipe;
  logic            ld1, ld2, ld3;
  s1_t             s1_q, s1_d;
  s2_t             s2_q, s2_d;
  s3_t             s3_q, s3_d;

  logic [LW-1:0]    lead;
  logic [SUM_W-1:0] norm;
  logic             inc, carry, ovf, unf;
  logic [MAN_W:0]   man_inc;
  logic [MAN_W-1:0] man_rnd;
  logic [EW-1:0]    e;

  // Ready ripples back combinationally so bubbles compress under backpressure.
  assign ld3      = !vld_q[3] || i_ready;
  assign ld2      = !vld_q[2] || ld3;
  assign ld1      = !vld_q[1] || ld2;
  assign o_ready  = ld1;
  assign vld_pipe = {vld_q, i_valid};

  always_comb begin
    vld_d = vld_q;
    if (ld1) vld_d[1] = vld_pipe[0];
    if (ld2) vld_d[2] = vld_pipe[1];
    if (ld3) vld_d[3] = vld_pipe[2];
  end

  always_comb begin
    s1_d = s1_q;
    if (ld1 && i_valid) begin
      s1_d.sign = i_sum[SUM_W-1];
      s1_d.mag  = i_sum[SUM_W-1] ? -i_sum : i_sum;
      s1_d.rtz  = i_rnd_mode;
      s1_d.exp  = i_exp;
    end
  end

  always_comb begin
    lead = '0;
    for (int i = 0; i < SUM_W; i++)
      if (s1_q.mag[i]) lead = LW'(i);
  end

  // Left-justify the leading one at the top bit; mantissa, round and sticky
  // then sit at fixed positions and anything below bit 0 is zero-filled.
  assign norm = s1_q.mag << (TOP - lead);

  always_comb begin
    s2_d = s2_q;
    if (ld2 && vld_q[1]) begin
      s2_d.sign   = s1_q.sign;
      s2_d.rtz    = s1_q.rtz;
      s2_d.exp    = s1_q.exp;
      s2_d.zero   = (s1_q.mag == '0);
      s2_d.shift  = SH_W'({1'b0, lead}) - SH_W'(POINT);
      s2_d.man    = norm[SUM_W-1 -: MAN_W];
      s2_d.rbit   = norm[SUM_W-1-MAN_W];
      s2_d.sticky = |(norm << (MAN_W + 1));
    end
  end

  always_comb begin
    inc     = !s2_q.rtz && s2_q.rbit && (s2_q.man[0] || s2_q.sticky);
    man_inc = {1'b0, s2_q.man} + {{MAN_W{1'b0}}, inc};
    carry   = man_inc[MAN_W];
    man_rnd = carry ? {1'b1, {(MAN_W-1){1'b0}}} : man_inc[MAN_W-1:0];
    e       = {2'b00, s2_q.exp} + EW'($signed(s2_q.shift)) + {{(EW-1){1'b0}}, carry};
    ovf     = !e[EW-1] && (e >= EMAX);
    unf     = e[EW-1] || (e == '0);
  end

  always_comb begin
    s3_d = s3_q;
    if (ld3 && vld_q[2]) begin
      s3_d      = '0;
      s3_d.sign = s2_q.sign;
      if (s2_q.zero) begin
        s3_d.zero = 1'b1;
      end else begin
        s3_d.shift = s2_q.shift;
        if (ovf) begin
          s3_d.ovf = 1'b1;
          s3_d.exp = '1;
        end else if (unf) begin
          s3_d.unf = 1'b1;
        end else begin
          s3_d.exp = e[EXP_W-1:0];
          s3_d.man = man_rnd;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
    end else begin
      vld_q <= vld_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
    end
  end

  assign o_valid = vld_q[3];
  assign o_sign  = s3_q.sign;
  assign o_man   = s3_q.man;
  assign o_exp   = s3_q.exp;
  assign o_shift = s3_q.shift;
  assign o_zero  = s3_q.zero;
  assign o_ovf   = s3_q.ovf;
  assign o_unf   = s3_q.unf;

endmodule

// File: tb/tb_final_norm_round_pipe.sv
// Randomised bench for final_norm_round_pipe: an arithmetic model predicts each
// result, a negedge monitor scoreboards outputs, directed cases cover flow control.
module tb_final_norm_round_pipe;

  logic        clk, rst_n;
  logic        i_valid, o_ready, i_ready, i_rnd_mode;
  logic [18:0] i_sum;
  logic [4:0]  i_exp;
  logic        o_valid, o_sign, o_zero, o_ovf, o_unf;
  logic [10:0] o_man;
  logic [4:0]  o_exp;
  logic [5:0]  o_shift;
  logic [25:0] dut_out;

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  logic [25:0] exp_q[$];
  bit          hold_chk = 0;
  logic [25:0] hold_val;

  final_norm_round_pipe dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_sum(i_sum), .i_exp(i_exp), .i_rnd_mode(i_rnd_mode), .o_valid(o_valid),
    .i_ready(i_ready), .o_sign(o_sign), .o_man(o_man), .o_exp(o_exp),
    .o_shift(o_shift), .o_zero(o_zero), .o_ovf(o_ovf), .o_unf(o_unf)
  );

  assign dut_out = {o_sign, o_man, o_exp, o_shift, o_zero, o_ovf, o_unf};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endfunction

  function automatic logic [25:0] pk(logic s, logic [10:0] m, logic [4:0] e,
                                     logic [5:0] d, logic z, logic o, logic u);
    return {s, m, e, d, z, o, u};
  endfunction

  // Reference: real-number view of the rules. Mantissa = top 11 significant
  // bits of |sum|, remainder compared against half an ulp for nearest-even.
  function automatic logic [25:0] model(logic [18:0] sum, logic [4:0] ex, logic rtz);
    int mag, lpos, sh, m, rem, half, e, c, d;
    bit inc;
    logic sg;
    sg  = sum[18];
    mag = sg ? (1 << 19) - int'(sum) : int'(sum);
    if (mag == 0) return pk(sg, 11'd0, 5'd0, 6'd0, 1'b1, 1'b0, 1'b0);
    lpos = $clog2(mag + 1) - 1;
    d    = lpos - 13;
    sh   = lpos - 10;
    inc  = 1'b0;
    if (sh > 0) begin
      m    = mag >> sh;
      rem  = mag - (m << sh);
      half = 1 << (sh - 1);
      inc  = !rtz && (rem > half || (rem == half && (m % 2) == 1));
    end else begin
      m = mag << (-sh);
    end
    m = m + int'(inc);
    c = 0;
    if (m == 2048) begin m = 1024; c = 1; end
    e = int'(ex) + d + c;
    if (e >= 31) return pk(sg, 11'd0, 5'd31, 6'(d), 1'b0, 1'b1, 1'b0);
    if (e <= 0)  return pk(sg, 11'd0, 5'd0, 6'(d), 1'b0, 1'b0, 1'b1);
    return pk(sg, 11'(m), 5'(e), 6'(d), 1'b0, 1'b0, 1'b0);
  endfunction

  // Single compare process: scoreboard on output transfers, hold check on stalls.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_chk = 0;
    end else begin
      if (hold_chk) chk("hold_stable", {5'd0, o_valid, dut_out}, {5'd0, 1'b1, hold_val});
      if (o_valid && i_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_out: got %h expected none", dut_out);
        end else begin
          chk("out", {6'd0, dut_out}, {6'd0, exp_q.pop_front()});
        end
      end
      if (i_valid && o_ready) exp_q.push_back(model(i_sum, i_exp, i_rnd_mode));
      hold_chk = o_valid && !i_ready;
      hold_val = dut_out;
    end
  end

  task automatic drive(input logic [18:0] s, input logic [4:0] e, input logic r);
    bit acc;
    int n;
    i_valid = 1'b1; i_sum = s; i_exp = e; i_rnd_mode = r;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk); acc = o_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL drive_timeout: got no accept expected accept");
    end
  endtask

  function automatic logic [18:0] rand_sum();
    logic [18:0] s;
    s = 19'($urandom);
    case ($urandom_range(0, 5))
      0: ;
      1: s = s >> $urandom_range(0, 18);
      2: s = -(s >> $urandom_range(0, 18));
      3: case ($urandom_range(0, 5))
           0: s = 19'h00000;
           1: s = 19'h40000;
           2: s = 19'h7FFFF;
           3: s = 19'h3FFC0;
           4: s = 19'h20040;
           default: s = 19'h00001;
         endcase
      4: s = (19'h3FF80 | 19'($urandom_range(0, 127))) >> $urandom_range(0, 12);
      default: s = (19'h20040 | (19'($urandom_range(0, 3)) << 7)) >> $urandom_range(0, 8);
    endcase
    return s;
  endfunction

  logic [18:0] dsum [11];
  logic [4:0]  dexp [11];
  logic        drnd [11];
  logic [25:0] dres [11];
  int base;

  initial begin
    dsum = '{19'h02000, 19'h7E000, 19'h20000, 19'h3FFC0, 19'h3FFC0, 19'h20040,
             19'h200C0, 19'h20000, 19'h00008, 19'h00000, 19'h40000};
    dexp = '{5'd15, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15, 5'd30, 5'd5, 5'd15, 5'd15};
    drnd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    dres[0]  = pk(1'b0, 11'h400, 5'd15, 6'd0,  1'b0, 1'b0, 1'b0);
    dres[1]  = pk(1'b1, 11'h400, 5'd15, 6'd0,  1'b0, 1'b0, 1'b0);
    dres[2]  = pk(1'b0, 11'h400, 5'd19, 6'd4,  1'b0, 1'b0, 1'b0);
    dres[3]  = pk(1'b0, 11'h400, 5'd20, 6'd4,  1'b0, 1'b0, 1'b0);
    dres[4]  = pk(1'b0, 11'h7FF, 5'd19, 6'd4,  1'b0, 1'b0, 1'b0);
    dres[5]  = pk(1'b0, 11'h400, 5'd19, 6'd4,  1'b0, 1'b0, 1'b0);
    dres[6]  = pk(1'b0, 11'h402, 5'd19, 6'd4,  1'b0, 1'b0, 1'b0);
    dres[7]  = pk(1'b0, 11'h000, 5'd31, 6'd4,  1'b0, 1'b1, 1'b0);
    dres[8]  = pk(1'b0, 11'h000, 5'd0,  6'h36, 1'b0, 1'b0, 1'b1);
    dres[9]  = pk(1'b0, 11'h000, 5'd0,  6'd0,  1'b1, 1'b0, 1'b0);
    dres[10] = pk(1'b1, 11'h400, 5'd20, 6'd5,  1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 11; k++)
      chk($sformatf("model_pin%0d", k), {6'd0, model(dsum[k], dexp[k], drnd[k])}, {6'd0, dres[k]});

    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_sum = '0; i_exp = '0; i_rnd_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {5'd0, o_valid, dut_out}, 32'd0);
    #2 rst_n = 1'b1;
    #1 chk("reset_ready", {31'd0, o_ready}, 32'd1);

    // Directed vectors back-to-back at full throughput.
    @(posedge clk); #1;
    for (int k = 0; k < 11; k++) drive(dsum[k], dexp[k], drnd[k]);
    i_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    // Backpressure: fill with ready low, then drain in order.
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) drive(dsum[k], dexp[k], drnd[k]);
    i_valid = 1'b1; i_sum = dsum[3]; i_exp = dexp[3]; i_rnd_mode = drnd[3];
    @(negedge clk);
    chk("bp_ready_low", {31'd0, o_ready}, 32'd0);
    chk("bp_valid_high", {31'd0, o_valid}, 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    i_ready = 1'b1;
    base = n_out;
    drive(dsum[3], dexp[3], drnd[3]);
    drive(dsum[4], dexp[4], drnd[4]);
    i_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("bp_burst_count", 32'(n_out - base), 32'd5);

    // Reset with three transactions in flight.
    @(posedge clk); #1;
    i_ready = 1'b0;
    for (int k = 5; k < 8; k++) drive(dsum[k], dexp[k], drnd[k]);
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("midrst_clear", {5'd0, o_valid, dut_out}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("midrst_ready", {31'd0, o_ready}, 32'd1);
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b1; i_sum = dsum[2]; i_exp = dexp[2]; i_rnd_mode = drnd[2];
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("lat_edge1", {31'd0, o_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_edge2", {31'd0, o_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_edge3", {5'd0, o_valid, dut_out}, {5'd0, 1'b1, dres[2]});

    // Randomised traffic with random backpressure.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      i_ready    = ($urandom_range(0, 3) != 0);
      i_valid    = ($urandom_range(0, 3) != 0);
      i_sum      = rand_sum();
      i_exp      = 5'($urandom);
      i_rnd_mode = 1'($urandom);
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_ready = 1'b1;
    repeat (8) @(negedge clk);
    #1 chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
